// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle RV64 controller sequencing IR, PC, regfile, ULA and data memory
module control_unit #(
  parameter int CNT_WIDTH       = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  output logic                 ir_load,
  output logic                 load_pc,
  output logic                 reset_pc,
  output logic                 pc_next_sel,
  output logic                 WE_RF,
  output logic                 WE_MEM,
  output logic                 RF_din_sel,
  output logic                 ULA_din2_sel,
  output logic                 sub,
  output logic                 busy,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_SD, C_BR, C_ILL
  } class_t;

  state_t state_q, state_d;
  class_t class_q, class_d;
  logic   illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic   ir_load_q, ir_load_d, load_pc_q, load_pc_d, reset_pc_q, reset_pc_d;
  logic   pc_next_sel_q, pc_next_sel_d, we_rf_q, we_rf_d, we_mem_q, we_mem_d;
  logic   rf_din_sel_q, rf_din_sel_d, ula_din2_sel_q, ula_din2_sel_d;
  logic   sub_q, sub_d, busy_q, busy_d;

  // Next state, latched class, and the Moore outputs of the state being entered
  always_comb begin
    state_d        = state_q;
    class_d        = class_q;
    illegal_d      = illegal_q;
    ir_load_d      = 1'b0;
    load_pc_d      = 1'b0;
    reset_pc_d     = 1'b0;
    pc_next_sel_d  = 1'b0;
    we_rf_d        = 1'b0;
    we_mem_d       = 1'b0;
    rf_din_sel_d   = 1'b0;
    ula_din2_sel_d = 1'b0;
    sub_d          = 1'b0;
    busy_d         = 1'b0;
    // Every instruction ends on exactly one load_pc cycle, so retire on its closing edge
    retired_d      = load_pc_q ? retired_q + CNT_WIDTH'(1) : retired_q;

    case (state_q)
      S_INIT:   state_d = S_IDLE;
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = run ? S_DECODE : S_IDLE;
      S_DECODE: begin
        if (opcode == 7'b0110011 && funct3 == 3'b000)      class_d = C_R;
        else if (opcode == 7'b0010011 && funct3 == 3'b000) class_d = C_I;
        else if (opcode == 7'b0000011 && funct3 == 3'b011) class_d = C_LD;
        else if (opcode == 7'b0100011 && funct3 == 3'b011) class_d = C_SD;
        else if (opcode == 7'b1100011)                     class_d = C_BR;
        else                                               class_d = C_ILL;
        if (class_d == C_ILL) begin
          illegal_d = 1'b1;
          state_d   = HALT_ON_ILLEGAL ? S_HALT : S_EXEC;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_R, C_I:   state_d = S_WB;
          C_LD, C_SD: state_d = S_MEM;
          default:    state_d = S_FETCH;
        endcase
      end
      S_MEM:    state_d = (class_q == C_LD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase

    case (state_d)
      S_INIT:   reset_pc_d = 1'b1;
      S_FETCH:  begin ir_load_d = 1'b1; busy_d = 1'b1; end
      S_DECODE: busy_d = 1'b1;
      S_EXEC: begin
        busy_d         = 1'b1;
        ula_din2_sel_d = (class_d == C_I) || (class_d == C_LD) || (class_d == C_SD);
        sub_d          = ((class_d == C_R) && funct7_5) || (class_d == C_BR);
        if (class_d == C_BR) begin
          load_pc_d     = 1'b1;
          pc_next_sel_d = 1'b1;
        end
        if (class_d == C_ILL) load_pc_d = 1'b1;
      end
      S_MEM: begin
        busy_d         = 1'b1;
        ula_din2_sel_d = 1'b1;
        if (class_d == C_SD) begin
          we_mem_d  = 1'b1;
          load_pc_d = 1'b1;
        end
      end
      S_WB: begin
        busy_d         = 1'b1;
        we_rf_d        = 1'b1;
        load_pc_d      = 1'b1;
        rf_din_sel_d   = (class_d != C_LD);
        ula_din2_sel_d = ula_din2_sel_q;
        sub_d          = sub_q;
      end
      default: ;
    endcase
  end

  // State, class, flags and registered strobes; reset aborts any instruction in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= S_INIT;
      class_q        <= C_ILL;
      illegal_q      <= 1'b0;
      retired_q      <= '0;
      ir_load_q      <= 1'b0;
      load_pc_q      <= 1'b0;
      reset_pc_q     <= 1'b1;
      pc_next_sel_q  <= 1'b0;
      we_rf_q        <= 1'b0;
      we_mem_q       <= 1'b0;
      rf_din_sel_q   <= 1'b0;
      ula_din2_sel_q <= 1'b0;
      sub_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      class_q        <= class_d;
      illegal_q      <= illegal_d;
      retired_q      <= retired_d;
      ir_load_q      <= ir_load_d;
      load_pc_q      <= load_pc_d;
      reset_pc_q     <= reset_pc_d;
      pc_next_sel_q  <= pc_next_sel_d;
      we_rf_q        <= we_rf_d;
      we_mem_q       <= we_mem_d;
      rf_din_sel_q   <= rf_din_sel_d;
      ula_din2_sel_q <= ula_din2_sel_d;
      sub_q          <= sub_d;
      busy_q         <= busy_d;
    end
  end

  assign ir_load      = ir_load_q;
  assign load_pc      = load_pc_q;
  assign reset_pc     = reset_pc_q;
  assign pc_next_sel  = pc_next_sel_q;
  assign WE_RF        = we_rf_q;
  assign WE_MEM       = we_mem_q;
  assign RF_din_sel   = rf_din_sel_q;
  assign ULA_din2_sel = ula_din2_sel_q;
  assign sub          = sub_q;
  assign busy         = busy_q;
  assign illegal      = illegal_q;
  assign retired      = retired_q;

endmodule
